// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction memory request/response bus for fetch_stage
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ready
    );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - IF stage with IF/ID register, stall hold and redirect kill; option FETCH_ALIGN_CHECK_EN
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_we,
    input  logic              flush,
    input  logic [1:0]        m4_1_cnt,
    input  logic [31:0]       branch_target,
    input  logic [31:0]       jalr_target,
    fetch_stage_if.master     imem,
    output logic [31:0]       id_inst,
    output logic [31:0]       id_pc,
    output logic [31:0]       id_pc4,
    output logic              id_valid,
    output logic              fetch_fault
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_KILL  = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] hold_reg, hold_n;
    logic [31:0] kill_addr, kill_n;
    logic [31:0] inst_n, idpc_n, idpc4_n;
    logic        valid_n;
    logic [31:0] raw_target, target, pc_plus4;

    assign pc_plus4   = pc + 32'd4;
    assign raw_target = (m4_1_cnt == 2'b10) ? (jalr_target & ~32'h1) : branch_target;

`ifdef FETCH_ALIGN_CHECK_EN
    logic fault_q, fault_n;
    assign target      = raw_target;
    assign fetch_fault = fault_q;
`else
    assign target      = raw_target & 32'hFFFF_FFFC;
    assign fetch_fault = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_FETCH;
            pc        <= RESET_PC;
            hold_reg  <= 32'd0;
            kill_addr <= 32'd0;
            id_inst   <= NOP_INST;
            id_pc     <= 32'd0;
            id_pc4    <= 32'd0;
            id_valid  <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            fault_q   <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            hold_reg  <= hold_n;
            kill_addr <= kill_n;
            id_inst   <= inst_n;
            id_pc     <= idpc_n;
            id_pc4    <= idpc4_n;
            id_valid  <= valid_n;
`ifdef FETCH_ALIGN_CHECK_EN
            fault_q   <= fault_n;
`endif
        end
    end

    always_comb begin
        state_n        = state;
        pc_n           = pc;
        hold_n         = hold_reg;
        kill_n         = kill_addr;
        inst_n         = id_inst;
        idpc_n         = id_pc;
        idpc4_n        = id_pc4;
        valid_n        = id_valid;
        imem.imem_req  = 1'b0;
        imem.imem_addr = pc;
`ifdef FETCH_ALIGN_CHECK_EN
        fault_n        = fault_q;
`endif

        case (state)
            S_FETCH: begin
                imem.imem_req = 1'b1;
                if (flush) begin
                    inst_n  = NOP_INST;
                    valid_n = 1'b0;
                    pc_n    = target;
                    if (!imem.imem_ready) begin
                        kill_n  = pc;
                        state_n = S_KILL;
                    end
                end else if (imem.imem_ready) begin
                    if (if_we) begin
                        inst_n  = imem.imem_rdata;
                        idpc_n  = pc;
                        idpc4_n = pc_plus4;
                        valid_n = 1'b1;
                        pc_n    = pc_plus4;
                    end else begin
                        hold_n  = imem.imem_rdata;
                        state_n = S_HOLD;
                    end
                end else if (if_we) begin
                    inst_n  = NOP_INST;
                    valid_n = 1'b0;
                end
            end
            S_HOLD: begin
                if (flush) begin
                    inst_n  = NOP_INST;
                    valid_n = 1'b0;
                    hold_n  = 32'd0;
                    pc_n    = target;
                    state_n = S_FETCH;
                end else if (if_we) begin
                    inst_n  = hold_reg;
                    idpc_n  = pc;
                    idpc4_n = pc_plus4;
                    valid_n = 1'b1;
                    pc_n    = pc_plus4;
                    state_n = S_FETCH;
                end
            end
            S_KILL: begin
                // The cancelled request must stay on the bus until memory answers it.
                imem.imem_req  = 1'b1;
                imem.imem_addr = kill_addr;
                if (flush) begin
                    inst_n  = NOP_INST;
                    valid_n = 1'b0;
                    pc_n    = target;
                end else if (if_we) begin
                    inst_n  = NOP_INST;
                    valid_n = 1'b0;
                end
                if (imem.imem_ready) state_n = S_FETCH;
            end
            default: state_n = S_FETCH;
        endcase

`ifdef FETCH_ALIGN_CHECK_EN
        if (fault_q) begin
            state_n       = state;
            pc_n          = pc;
            hold_n        = hold_reg;
            kill_n        = kill_addr;
            inst_n        = NOP_INST;
            valid_n       = 1'b0;
            imem.imem_req = 1'b0;
        end else if (flush && (raw_target[1:0] != 2'b00)) begin
            fault_n = 1'b1;
        end
`endif
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage with a program-order reference model
module tb_fetch_stage;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_we;
    logic        flush;
    logic [1:0]  m4_1_cnt;
    logic [31:0] branch_target;
    logic [31:0] jalr_target;
    logic [31:0] id_inst, id_pc, id_pc4;
    logic        id_valid;
    logic        fetch_fault;

    int n_checks = 0;
    int n_pass   = 0;

    fetch_stage_if bus ();

    fetch_stage #(.RESET_PC(RESET_PC), .NOP_INST(NOP)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .if_we         (if_we),
        .flush         (flush),
        .m4_1_cnt      (m4_1_cnt),
        .branch_target (branch_target),
        .jalr_target   (jalr_target),
        .imem          (bus),
        .id_inst       (id_inst),
        .id_pc         (id_pc),
        .id_pc4        (id_pc4),
        .id_valid      (id_valid),
        .fetch_fault   (fetch_fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h0123_4567;
    endfunction

    task automatic cyc(input logic we, input logic fl, input logic rdy,
                       input logic [1:0] m4, input logic [31:0] bt, input logic [31:0] jt);
        if_we          = we;
        flush          = fl;
        bus.imem_ready = rdy;
        m4_1_cnt       = m4;
        branch_target  = bt;
        jalr_target    = jt;
        bus.imem_rdata = mem(bus.imem_addr);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_ready(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b1, 2'b00, 32'd0, 32'd0);
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        if_we          = 1'b0;
        flush          = 1'b0;
        m4_1_cnt       = 2'b00;
        branch_target  = 32'd0;
        jalr_target    = 32'd0;
        bus.imem_ready = 1'b0;
        bus.imem_rdata = 32'd0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        bus.imem_ready = 1'b1;
        if_we          = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({bus.imem_req, bus.imem_addr} !== {1'b1, RESET_PC})
            $display("FAIL reset_req got %b/%h exp 1/%h", bus.imem_req, bus.imem_addr, RESET_PC);
        else n_pass++;
        n_checks++;
        if ({id_valid, id_inst, id_pc, id_pc4, fetch_fault} !== {1'b0, NOP, 32'd0, 32'd0, 1'b0})
            $display("FAIL reset_id got v=%b i=%h pc=%h pc4=%h f=%b", id_valid, id_inst, id_pc, id_pc4, fetch_fault);
        else n_pass++;
    endtask

    task automatic test_sequential();
        do_reset();
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'(4 * k)})
                $display("FAIL seq_addr k=%0d got %h exp %h", k, bus.imem_addr, 32'(4 * k));
            else n_pass++;
            if (k > 0) begin
                n_checks++;
                if ({id_valid, id_pc, id_inst} !== {1'b1, 32'(4 * (k - 1)), mem(32'(4 * (k - 1)))})
                    $display("FAIL seq_id k=%0d got v=%b pc=%h i=%h exp pc=%h", k, id_valid, id_pc, id_inst, 32'(4 * (k - 1)));
                else n_pass++;
            end
            cyc(1'b1, 1'b0, 1'b1, 2'b00, 32'd0, 32'd0);
        end
    endtask

    task automatic test_bubbles();
        do_reset();
        run_ready(4);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
            n_checks++;
            if ({id_valid, id_inst, bus.imem_addr} !== {1'b0, NOP, 32'h10})
                $display("FAIL bubble k=%0d got v=%b i=%h addr=%h exp 0/%h/10", k, id_valid, id_inst, bus.imem_addr, NOP);
            else n_pass++;
        end
        cyc(1'b1, 1'b0, 1'b1, 2'b00, 32'd0, 32'd0);
        n_checks++;
        if ({id_valid, id_pc, id_inst} !== {1'b1, 32'h10, mem(32'h10)})
            $display("FAIL bubble_resume got v=%b pc=%h i=%h exp 1/10/%h", id_valid, id_pc, id_inst, mem(32'h10));
        else n_pass++;
    endtask

    task automatic test_hold();
        do_reset();
        run_ready(8);
        n_checks++;
        if (bus.imem_addr !== 32'h20) $display("FAIL hold_pre got %h exp 20", bus.imem_addr);
        else n_pass++;
        for (int k = 0; k < 2; k++) begin
            cyc(1'b0, 1'b0, (k == 0), 2'b00, 32'd0, 32'd0);
            n_checks++;
            if ({bus.imem_req, id_pc, id_valid} !== {1'b0, 32'h1C, 1'b1})
                $display("FAIL hold_stall k=%0d got req=%b pc=%h v=%b exp 0/1c/1", k, bus.imem_req, id_pc, id_valid);
            else n_pass++;
        end
        cyc(1'b1, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
        n_checks++;
        if ({id_valid, id_pc, id_inst, bus.imem_req, bus.imem_addr} !== {1'b1, 32'h20, mem(32'h20), 1'b1, 32'h24})
            $display("FAIL hold_release got v=%b pc=%h i=%h req=%b addr=%h", id_valid, id_pc, id_inst, bus.imem_req, bus.imem_addr);
        else n_pass++;
    endtask

    task automatic test_kill();
        do_reset();
        run_ready(16);
        cyc(1'b1, 1'b1, 1'b0, 2'b10, 32'h0000_0500, 32'h0000_0101);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if ({bus.imem_req, bus.imem_addr, id_valid} !== {1'b1, 32'h40, 1'b0})
                $display("FAIL kill_hold k=%0d got req=%b addr=%h v=%b exp 1/40/0", k, bus.imem_req, bus.imem_addr, id_valid);
            else n_pass++;
            cyc(1'b1, 1'b0, (k == 2), 2'b00, 32'd0, 32'd0);
        end
        n_checks++;
        if ({bus.imem_addr, id_valid} !== {32'h100, 1'b0})
            $display("FAIL kill_redirect got addr=%h v=%b exp 100/0", bus.imem_addr, id_valid);
        else n_pass++;
        cyc(1'b1, 1'b0, 1'b1, 2'b00, 32'd0, 32'd0);
        n_checks++;
        if ({id_valid, id_pc, id_inst} !== {1'b1, 32'h100, mem(32'h100)})
            $display("FAIL kill_first got v=%b pc=%h i=%h", id_valid, id_pc, id_inst);
        else n_pass++;
    endtask

    task automatic test_hold_flush();
        do_reset();
        run_ready(2);
        cyc(1'b0, 1'b0, 1'b1, 2'b00, 32'd0, 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 2'b00, 32'h0000_0300, 32'd0);
        n_checks++;
        if ({bus.imem_req, bus.imem_addr, id_valid} !== {1'b1, 32'h300, 1'b0})
            $display("FAIL hold_flush got req=%b addr=%h v=%b exp 1/300/0", bus.imem_req, bus.imem_addr, id_valid);
        else n_pass++;
        cyc(1'b1, 1'b0, 1'b1, 2'b00, 32'd0, 32'd0);
        n_checks++;
        if ({id_valid, id_pc, id_inst} !== {1'b1, 32'h300, mem(32'h300)})
            $display("FAIL hold_flush_first got v=%b pc=%h i=%h", id_valid, id_pc, id_inst);
        else n_pass++;
    endtask

    task automatic test_wrap();
        do_reset();
        cyc(1'b1, 1'b1, 1'b1, 2'b00, 32'hFFFF_FFFC, 32'd0);
        cyc(1'b1, 1'b0, 1'b1, 2'b00, 32'd0, 32'd0);
        n_checks++;
        if ({id_pc, id_pc4, bus.imem_addr} !== {32'hFFFF_FFFC, 32'd0, 32'd0})
            $display("FAIL wrap got pc=%h pc4=%h addr=%h exp fffffffc/0/0", id_pc, id_pc4, bus.imem_addr);
        else n_pass++;
    endtask

    task automatic test_align();
        do_reset();
        run_ready(2);
        cyc(1'b1, 1'b1, 1'b1, 2'b00, 32'h0000_0202, 32'd0);
`ifdef FETCH_ALIGN_CHECK_EN
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if ({fetch_fault, bus.imem_req, id_valid} !== 3'b100)
                $display("FAIL align_fault k=%0d got f=%b req=%b v=%b exp 1/0/0", k, fetch_fault, bus.imem_req, id_valid);
            else n_pass++;
            cyc(1'b1, 1'b0, 1'b1, 2'b00, 32'd0, 32'd0);
        end
        do_reset();
        n_checks++;
        if ({fetch_fault, bus.imem_req} !== 2'b01)
            $display("FAIL align_clear got f=%b req=%b exp 0/1", fetch_fault, bus.imem_req);
        else n_pass++;
`else
        n_checks++;
        if ({bus.imem_addr, fetch_fault} !== {32'h200, 1'b0})
            $display("FAIL align_force got addr=%h f=%b exp 200/0", bus.imem_addr, fetch_fault);
        else n_pass++;
`endif
    endtask

    task automatic test_async_reset();
        do_reset();
        run_ready(3);
        cyc(1'b1, 1'b1, 1'b0, 2'b00, 32'h0000_0500, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.imem_req, bus.imem_addr, id_valid, id_pc} !== {1'b1, RESET_PC, 1'b0, 32'd0})
            $display("FAIL async_reset got req=%b addr=%h v=%b pc=%h", bus.imem_req, bus.imem_addr, id_valid, id_pc);
        else n_pass++;
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b1, 1'b0, 1'b1, 2'b00, 32'd0, 32'd0);
        n_checks++;
        if ({id_valid, id_pc, id_inst} !== {1'b1, RESET_PC, mem(RESET_PC)})
            $display("FAIL async_restart got v=%b pc=%h i=%h", id_valid, id_pc, id_inst);
        else n_pass++;
    endtask

    // Program-order model: every issued word is the next sequential PC since the last redirect.
    task automatic test_random();
        logic [31:0] exp_pc, bt, jt, tgt, prev_addr, prev_inst, prev_pc;
        logic        we, fl, rdy, prev_req, prev_rdy, prev_valid;
        logic [1:0]  m4;
        int          issued, errs;
        do_reset();
        exp_pc   = RESET_PC;
        issued   = 0;
        errs     = 0;
        prev_req = 1'b0;
        prev_rdy = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            we  = ($urandom % 4) != 0;
            rdy = ($urandom % 3) != 0;
            fl  = ($urandom % 16) == 0;
            m4  = 2'($urandom);
            bt  = $urandom & 32'hFFFF_FFFC;
            jt  = ($urandom & 32'hFFFF_FFF8) | 32'($urandom % 2);
            tgt = (m4 == 2'b10) ? (jt & ~32'h1) : bt;
            if (prev_req && !prev_rdy && errs < 10) begin
                n_checks++;
                if ({bus.imem_req, bus.imem_addr} !== {1'b1, prev_addr}) begin
                    errs++;
                    $display("FAIL rnd_addr_stable c=%0d got %b/%h exp 1/%h", c, bus.imem_req, bus.imem_addr, prev_addr);
                end else n_pass++;
            end
            prev_req   = bus.imem_req;
            prev_addr  = bus.imem_addr;
            prev_rdy   = rdy;
            prev_valid = id_valid;
            prev_inst  = id_inst;
            prev_pc    = id_pc;
            cyc(we, fl, rdy, m4, bt, jt);
            if (errs < 10) begin
                n_checks++;
                if (fl) begin
                    exp_pc = tgt;
                    if ({id_valid, id_inst} !== {1'b0, NOP}) begin
                        errs++;
                        $display("FAIL rnd_flush c=%0d got v=%b i=%h", c, id_valid, id_inst);
                    end else n_pass++;
                end else if (we && id_valid) begin
                    if ({id_pc, id_pc4, id_inst} !== {exp_pc, exp_pc + 32'd4, mem(exp_pc)}) begin
                        errs++;
                        $display("FAIL rnd_issue c=%0d got pc=%h i=%h exp pc=%h i=%h", c, id_pc, id_inst, exp_pc, mem(exp_pc));
                    end else n_pass++;
                    exp_pc = exp_pc + 32'd4;
                    issued++;
                end else if (we) begin
                    if (id_inst !== NOP) begin
                        errs++;
                        $display("FAIL rnd_bubble c=%0d got i=%h", c, id_inst);
                    end else n_pass++;
                end else begin
                    if ({id_valid, id_inst, id_pc} !== {prev_valid, prev_inst, prev_pc}) begin
                        errs++;
                        $display("FAIL rnd_stall c=%0d got v=%b i=%h pc=%h exp %b/%h/%h", c, id_valid, id_inst, id_pc, prev_valid, prev_inst, prev_pc);
                    end else n_pass++;
                end
            end
        end
        n_checks++;
        if (issued < 200) $display("FAIL rnd_progress got %0d issued exp >=200", issued);
        else n_pass++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        bus.imem_ready = 1'b0;
        bus.imem_rdata = 32'd0;
        if_we          = 1'b0;
        flush          = 1'b0;
        m4_1_cnt       = 2'b00;
        branch_target  = 32'd0;
        jalr_target    = 32'd0;
        test_reset();
        test_sequential();
        test_bubbles();
        test_hold();
        test_kill();
        test_hold_flush();
        test_wrap();
        test_align();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
